// File: rtl/kbd_rx_qbus.sv
// kbd_rx_qbus: 1801VM1-bus console keyboard receiver (TKS/TKB registers + vectored IRQ). Rev 1.0
// Build option KBD_RX_FIFO_EN selects a FIFO_DEPTH-entry receive FIFO instead of a single-byte buffer.
`default_nettype none

module kbd_rx_qbus #(
  parameter logic [15:0] BASE_ADDR  = 16'o177560,
  parameter logic [15:0] VECTOR     = 16'o000060,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ad_n_i,
  output logic [15:0] ad_n_o,
  output logic        ad_oe,
  input  logic        sync_n,
  input  logic        din_n,
  input  logic        dout_n,
  input  logic        wtbt_n,
  input  logic [1:0]  sel_n,
  input  logic        iako_n,
  output logic        rply_n_o,
  output logic        virq_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_RD       = 3'd2,
    S_IAK      = 3'd3,
    S_WR       = 3'd4,
    S_WAIT_END = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [1:0]  sel_q, sel_d;
  logic        ie_q, ie_d;
  logic        irq_q, irq_d;
  logic        cond_q;
  logic        rdy_q, rdy_d;
  logic [7:0]  last_q, last_d;

  logic        push, pop, done, hit, is_tkb, cond, ack;
  logic [7:0]  head_raw, head;

  assign push   = rx_valid && rdy_q;
  assign hit    = (sel_q == 2'b11) && (addr_q[15:2] == BASE_ADDR[15:2]);
  assign is_tkb = addr_q[1];
  // Pop only once the CPU has finished reading, so RD data never changes mid-cycle.
  assign pop    = (state_q == S_RD) && din_n && is_tkb && done;
  assign ack    = (state_q == S_IAK) && din_n;
  assign cond   = ie_q && done;
  assign head   = done ? head_raw : last_q;

`ifdef KBD_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done     = (cnt_q != '0);
  assign head_raw = mem_q[rd_ptr_q];
  assign rdy_d    = (cnt_d < (AW + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end
`else
  logic       full_q, full_d;
  logic [7:0] buf_q;
  logic       unused_fifo_depth;

  assign unused_fifo_depth = ^FIFO_DEPTH;

  always_comb begin
    full_d = full_q;
    if (pop)  full_d = 1'b0;
    if (push) full_d = 1'b1;
  end

  assign done     = full_q;
  assign head_raw = buf_q;
  assign rdy_d    = ~full_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q <= rx_data;
  end
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    rd_data_d = rd_data_q;
    ie_d      = ie_q;
    last_d    = pop ? head_raw : last_q;

    if (state_q != S_IDLE && sync_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!sync_n) begin
            addr_d  = ~ad_n_i;
            sel_d   = sel_n;
            state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          if (hit) begin
            if (!din_n) begin
              state_d   = S_RD;
              rd_data_d = is_tkb ? {8'h00, head} : {8'h00, done, ie_q, 6'b0};
            end else if (!dout_n) begin
              state_d = S_WR;
              // Odd-address byte writes land on the unused high byte of TKS.
              if (!is_tkb && (wtbt_n || !addr_q[0])) begin
                ie_d = ~ad_n_i[6];
              end
            end
          end else if (!iako_n) begin
            if (!din_n) begin
              state_d = irq_q ? S_IAK : S_WAIT_END;
            end
          end else begin
            state_d = S_WAIT_END;
          end
        end
        S_RD, S_IAK: begin
          if (din_n) state_d = S_WAIT_END;
        end
        S_WR: begin
          if (dout_n) state_d = S_WAIT_END;
        end
        S_WAIT_END: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (!cond || ack) begin
      irq_d = 1'b0;
    end else if (!cond_q) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sel_q     <= 2'b11;
      rd_data_q <= '0;
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
      cond_q    <= 1'b0;
      rdy_q     <= 1'b1;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      rd_data_q <= rd_data_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
      cond_q    <= cond;
      rdy_q     <= rdy_d;
      last_q    <= last_d;
    end
  end

  assign ad_oe    = (state_q == S_RD) || (state_q == S_IAK);
  assign ad_n_o   = (state_q == S_RD)  ? ~rd_data_q :
                    (state_q == S_IAK) ? ~VECTOR    : 16'hFFFF;
  assign rply_n_o = ~((state_q == S_RD) || (state_q == S_IAK) || (state_q == S_WR));
  assign virq_n   = ~irq_q;
  assign rx_ready = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_kbd_rx_qbus.sv
// tb_kbd_rx_qbus: randomized bus/host stimulus for kbd_rx_qbus against a queue-based register model.
`default_nettype none

module tb_kbd_rx_qbus;

`ifdef KBD_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam logic [15:0] C_TKS = 16'o177560;
  localparam logic [15:0] C_TKB = 16'o177562;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ad_n_i, ad_n_o;
  logic        ad_oe, sync_n, din_n, dout_n, wtbt_n, iako_n, rply_n_o, virq_n;
  logic [1:0]  sel_n;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  kbd_rx_qbus #(.BASE_ADDR(16'o177560), .VECTOR(16'o000060), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ad_n_i(ad_n_i), .ad_n_o(ad_n_o), .ad_oe(ad_oe),
    .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .sel_n(sel_n),
    .iako_n(iako_n), .rply_n_o(rply_n_o), .virq_n(virq_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Register model: the receive buffer is a plain queue of bytes.
  logic [7:0] mq[$];
  logic       m_ie = 1'b0, m_irq = 1'b0, m_cond_prev = 1'b0;
  logic [7:0] m_last = 8'h00;
  bit         pop_req = 0, ack_req = 0, iew_req = 0;
  logic       iew_val = 1'b0;
  bit         cmp_en = 0, host_rand = 0;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a[1]) return {8'h00, (mq.size() != 0) ? mq[0] : m_last};
    return {8'h00, (mq.size() != 0), m_ie, 6'b0};
  endfunction

  always @(posedge clk) begin
    bit cond, do_pop, do_push;
    if (!rst_n) begin
      mq.delete();
      m_ie = 1'b0; m_irq = 1'b0; m_cond_prev = 1'b0; m_last = 8'h00;
      pop_req = 0; ack_req = 0; iew_req = 0;
    end else begin
      cond    = m_ie && (mq.size() != 0);
      do_pop  = pop_req && (mq.size() != 0);
      do_push = rx_valid && (mq.size() < CAP);
      // Interrupt pends one clock after IE&&DONE becomes true; drops when either falls or on acknowledge.
      if (!cond || ack_req) m_irq = 1'b0;
      else if (!m_cond_prev) m_irq = 1'b1;
      m_cond_prev = cond;
      if (do_pop) m_last = mq.pop_front();
      if (do_push) mq.push_back(rx_data);
      if (iew_req) m_ie = iew_val;
      pop_req = 0; ack_req = 0; iew_req = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rx_ready", rx_ready, mq.size() < CAP);
      check("virq_n", virq_n, !m_irq);
    end
  end

  always @(negedge clk) begin
    if (host_rand) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 sync_n raised mid-RD, 2 rst_n pulsed mid-RD
  task automatic rd(input logic [15:0] a, input logic [1:0] sel, input int mode,
                    input bit push_rel, input logic [7:0] push_b, output logic [15:0] got);
    logic [15:0] exp, exp_n;
    bit hit;
    int k;
    hit = (sel == 2'b11) && (a[15:2] == C_TKS[15:2]);
    @(negedge clk); sync_n = 1'b0; ad_n_i = ~a; sel_n = sel;
    @(negedge clk); ad_n_i = 16'hFFFF; din_n = 1'b0; exp = model_read(a); exp_n = ~exp;
    @(negedge clk);
    got = ~ad_n_o;
    if (hit) begin
      k = 0;
      while (rply_n_o && k < 8) begin @(negedge clk); k++; end
      got = ~ad_n_o;
      check("rd_rply", rply_n_o, 1'b0);
      check("rd_oe", ad_oe, 1'b1);
      check("rd_data", ad_n_o, exp_n);
      if (mode == 1) begin
        sync_n = 1'b1;
        @(negedge clk);
        check("sync_abort_rply", rply_n_o, 1'b1);
        check("sync_abort_oe", ad_oe, 1'b0);
        din_n = 1'b1; sel_n = 2'b11;
        @(negedge clk);
      end else if (mode == 2) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_abort_rply", rply_n_o, 1'b1);
        check("rst_abort_oe", ad_oe, 1'b0);
        rst_n = 1'b1; din_n = 1'b1; sync_n = 1'b1; sel_n = 2'b11;
        @(negedge clk);
      end else begin
        @(negedge clk);
        check("rd_stable", ad_n_o, exp_n);
        din_n = 1'b1;
        pop_req = a[1];
        if (push_rel) begin rx_valid = 1'b1; rx_data = push_b; end
        @(negedge clk);
        if (push_rel) rx_valid = 1'b0;
        check("rd_rel_rply", rply_n_o, 1'b1);
        check("rd_rel_oe", ad_oe, 1'b0);
        check("rd_rel_ad", ad_n_o, 16'hFFFF);
        sync_n = 1'b1; sel_n = 2'b11;
        @(negedge clk);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        check("nohit_rply", rply_n_o, 1'b1);
        check("nohit_oe", ad_oe, 1'b0);
        @(negedge clk);
      end
      din_n = 1'b1; sync_n = 1'b1; sel_n = 2'b11;
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [1:0] sel, input logic [15:0] d, input bit byte_wr);
    bit hit;
    int k;
    hit = (sel == 2'b11) && (a[15:2] == C_TKS[15:2]);
    @(negedge clk); sync_n = 1'b0; ad_n_i = ~a; sel_n = sel;
    @(negedge clk); ad_n_i = ~d; dout_n = 1'b0; wtbt_n = !byte_wr;
    if (hit && !a[1] && (!byte_wr || !a[0])) begin iew_req = 1; iew_val = d[6]; end
    @(negedge clk);
    if (hit) begin
      k = 0;
      while (rply_n_o && k < 8) begin @(negedge clk); k++; end
      check("wr_rply", rply_n_o, 1'b0);
      check("wr_oe", ad_oe, 1'b0);
      dout_n = 1'b1;
      @(negedge clk);
      check("wr_rel_rply", rply_n_o, 1'b1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        check("nohit_wr_rply", rply_n_o, 1'b1);
        @(negedge clk);
      end
      dout_n = 1'b1;
    end
    sync_n = 1'b1; wtbt_n = 1'b1; sel_n = 2'b11; ad_n_i = 16'hFFFF;
    @(negedge clk);
  endtask

  task automatic iak();
    bit exp_rep;
    int k;
    @(negedge clk); sync_n = 1'b0; ad_n_i = 16'hFFFF; iako_n = 1'b0;
    @(negedge clk); din_n = 1'b0; exp_rep = m_irq;
    @(negedge clk);
    if (exp_rep) begin
      k = 0;
      while (rply_n_o && k < 8) begin @(negedge clk); k++; end
      check("iak_rply", rply_n_o, 1'b0);
      check("iak_oe", ad_oe, 1'b1);
      check("iak_vector", ad_n_o, 16'o177717);
      din_n = 1'b1; ack_req = 1;
      @(negedge clk);
      check("iak_rel_rply", rply_n_o, 1'b1);
      check("iak_virq_released", virq_n, 1'b1);
    end else begin
      check("iak_noreq_rply", rply_n_o, 1'b1);
      din_n = 1'b1;
    end
    iako_n = 1'b1; sync_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    rst_n = 1'b0; ad_n_i = 16'hFFFF; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
    wtbt_n = 1'b1; sel_n = 2'b11; iako_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ad_oe", ad_oe, 1'b0);
    check("rst_ad_n_o", ad_n_o, 16'hFFFF);
    check("rst_rply", rply_n_o, 1'b1);
    check("rst_virq", virq_n, 1'b1);
    check("rst_rx_ready", rx_ready, 1'b1);
    rst_n = 1'b1;
    cmp_en = 1;

    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("tks_after_reset", got, 16'o000000);
    wr(C_TKB, 2'b11, 16'o000101, 0);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("tks_after_tkb_write", got, 16'o000000);

    push(8'h41);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("tks_done", got, 16'o000200);
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("tkb_41", got, 16'o000101);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("tks_empty", got, 16'o000000);

    wr(C_TKS, 2'b11, 16'o000100, 0);
    push(8'h0D);
    check("virq_before", virq_n, 1'b1);
    @(negedge clk);
    check("virq_asserted", virq_n, 1'b0);
    iak();
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("tkb_0d", got, 16'o000015);
    wr(C_TKS, 2'b11, 16'o000000, 0);

`ifdef KBD_RX_FIFO_EN
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("fifo_full_ready", rx_ready, 1'b0);
    push(8'h05);
    for (int i = 1; i <= 4; i++) begin
      rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("fifo_order", got, 16'(i));
    end
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("fifo_drained", got, 16'o000000);
    push(8'hA1); push(8'hA2);
    rd(C_TKB, 2'b11, 0, 1, 8'hA3, got); check("pushpop_a1", got, 16'h00A1);
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("pushpop_a2", got, 16'h00A2);
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("pushpop_a3", got, 16'h00A3);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("pushpop_empty", got, 16'o000000);
`else
    push(8'h31);
    check("single_full_ready", rx_ready, 1'b0);
    push(8'h32);
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("single_first", got, 16'h0031);
    push(8'h32);
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("single_second", got, 16'h0032);
    push(8'hA1);
    rd(C_TKB, 2'b11, 0, 1, 8'hA3, got); check("pushpop_a1", got, 16'h00A1);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("pushpop_blocked", got, 16'o000000);
`endif

    rd(16'o177564, 2'b11, 0, 0, 8'h00, got);
    rd(C_TKS, 2'b10, 0, 0, 8'h00, got);
    wr(C_TKS, 2'b10, 16'o000100, 0);
    wr(C_TKS + 16'd1, 2'b11, 16'o000100, 1);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("odd_byte_ignored", got, 16'o000000);

    push(8'h55);
    rd(C_TKB, 2'b11, 1, 0, 8'h00, got); check("sync_abort_data", got, 16'h0055);
    rd(C_TKB, 2'b11, 0, 0, 8'h00, got); check("sync_abort_nopop", got, 16'h0055);

    push(8'h66);
    wr(C_TKS, 2'b11, 16'o000100, 0);
    rd(C_TKS, 2'b11, 2, 0, 8'h00, got);
    rd(C_TKS, 2'b11, 0, 0, 8'h00, got); check("after_rst_abort", got, 16'o000000);

    host_rand = 1;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 6))
        0: rd(C_TKS, 2'b11, 0, 0, 8'h00, got);
        1: rd(C_TKB, 2'b11, 0, 0, 8'h00, got);
        2: wr(($urandom_range(0, 1) != 0) ? C_TKS + 16'd1 : C_TKS, 2'b11,
              16'($urandom), $urandom_range(0, 1) != 0);
        3: wr(C_TKB, 2'b11, 16'($urandom), 0);
        4: if (m_irq) iak(); else repeat (2) @(negedge clk);
        5: rd(($urandom_range(0, 1) != 0) ? 16'o177564 : C_TKS,
              ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 0, 0, 8'h00, got);
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
    end
    host_rand = 0;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kbd_rx_qbus.md
# kbd_rx_qbus

Synthesizable console-keyboard receiver for the 1801VM1 system bus. It is the input counterpart of the TPS/TPB console transmitter. A host-side byte stream feeds it, and it presents the standard keyboard register pair TKS (177560) and TKB (177562) to the CPU as a bus responder. It also raises a vectored interrupt (VIRQ/IAKO) when a character is available. It sits on the CPU's AD/SYNC/DIN/DOUT/RPLY bus next to RAM and the other I/O responders.

## Interface
Parameters:
- BASE_ADDR, 16'o177560, TKS address; TKB is BASE_ADDR+2
- VECTOR, 16'o000060, interrupt vector returned during IAKO
- FIFO_DEPTH, 4, receive FIFO depth (power of two; only used with KBD_RX_FIFO_EN)

Ports:
- clk  in  1  system clock, same clock as the CPU pin_clk
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- ad_n_i  in  16  AD bus sampled (active-low)
- ad_n_o  out  16  AD bus drive value (active-low)
- ad_oe  out  1  AD tri-state enable, high = drive
- sync_n  in  1  bus SYNC
- din_n  in  1  bus DIN
- dout_n  in  1  bus DOUT
- wtbt_n  in  1  WTBT; low during the data phase = byte write
- sel_n  in  2  SEL; the block responds only when sel_n==2'b11
- iako_n  in  1  interrupt acknowledge
- rply_n_o  out  1  RPLY drive, active-low, open-drain style (1 = released)
- virq_n  out  1  vectored interrupt request, active-low
- rx_data  in  8  host character
- rx_valid  in  1  host character valid
- rx_ready  out  1  block can accept a character this cycle

## Operation
- Host side: a byte is accepted on any clk where rx_valid && rx_ready. rx_ready is registered and is high when the buffer is not full.
- TKS read: returns {8'h00, DONE, IE, 6'b0}. DONE means the buffer is not empty.
- TKS write: only when wtbt_n is high, or wtbt_n is low with addr[0]==0. IE is loaded from data bit 6. All other bits are ignored. A byte write to the odd address has no effect.
- TKB read: returns {8'h00, head byte}. A pop happens at the end of the DIN phase. Reading while empty returns the last byte and does not pop.
- TKB write: acknowledged with RPLY, otherwise ignored.
- Interrupt: irq_pend is set on the clk where (IE && DONE) rises. It is cleared when the vector is acknowledged, or when IE or DONE falls. virq_n = ~irq_pend.
- Bus FSM states:
  - IDLE → ADDR: on a sampled sync_n high→low, latch addr = ~ad_n_i and sel_n.
  - In ADDR, with sel_n==2'b11, addr[15:2]==BASE_ADDR[15:2]:
    - din_n low → RD.
    - dout_n low → WR.
  - In ADDR, iako_n && din_n both low with irq_pend set → IAK.
  - No match in ADDR → WAIT_END, with no drive and no RPLY.
- RD/IAK:
  - ad_oe=1, ad_n_o=~data (~VECTOR in IAK), rply_n_o=0.
  - When din_n is sampled high: release and go to WAIT_END. A TKB pop or irq_pend clear happens on that clk.
- WR: latch data on entry, rply_n_o=0. When dout_n is sampled high: release and go to WAIT_END.
- WAIT_END → IDLE when sync_n is sampled high.
- sync_n sampled high in any state releases everything immediately and returns to IDLE.

## Timing
- Reset values: ad_oe=0, ad_n_o=16'hFFFF, rply_n_o=1, virq_n=1, rx_ready=1, IE=0, buffer empty.
- Reset mid-transaction: all drives are released on the reset clk.
- Address is latched on the first clk edge where sync_n is sampled low.
- DIN/DOUT sampled low → RPLY and AD drive asserted on the next clk (1-cycle latency).
- DIN/DOUT sampled high → RPLY and AD released on the next clk.
- Read data is stable for the whole RD phase; the pop happens only at release.
- Push and pop on the same clk: both take effect. With the buffer full, the push is not offered because rx_ready is already low. Count is unchanged.
- DONE visible in TKS: 1 clk after an accepted push.
- virq_n falls 1 clk after (IE && DONE) rises.
- FIFO pointers are log2(FIFO_DEPTH) bits wide, wrap modulo depth, plus a separate count of log2+1 bits.

## Configuration
- KBD_RX_FIFO_EN defined: FIFO_DEPTH-entry FIFO. rx_ready = count<FIFO_DEPTH. DONE = count!=0.
- KBD_RX_FIFO_EN undefined: single-byte buffer. rx_ready = ~DONE. A new byte can only be pushed after the TKB pop. FIFO_DEPTH is ignored.

## Test plan
- Reset, then read TKS → 16'o000000 with RPLY. Write TKB 16'o000101 → RPLY, no state change.
- Push 8'h41, read TKS → 16'o000200. Read TKB → 16'o000101. Read TKS again → 16'o000000.
- Write TKS 16'o000100, then push 8'h0D → virq_n low 1 clk later. IAKO+DIN cycle → AD = ~16'o000060, RPLY, virq_n high after DIN release.
- FIFO_EN: push 4 bytes 1..4 → rx_ready=0 on the 4th. A 5th rx_valid is not accepted. Four TKB reads → 1,2,3,4. Without FIFO_EN: a second push is blocked until the first read.
- Same-clk push and TKB pop with count 2 → count stays 2, order preserved.
- Access at 177564 or with sel_n==2'b10 → no RPLY, no drive. sync_n raised mid-RD → immediate release. rst_n low mid-RD → RPLY released on that clk.
